// File: rtl/mem_access_unit.sv
// Load/store access sequencer between the execute stage, the MMU and a req/ack memory bus.
// Optional bus watchdog is compiled in with `define MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        res,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] vAddr,
  input  logic [31:0] pAddr,
  input  logic        tlbMiss,
  input  logic        tlbInvalid,
  input  logic        tlbModified,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [2:0]  resp_exc,
  output logic [31:0] resp_badVAddr
);

  typedef enum logic [1:0] {IDLE, XLATE, BUS, RESP} state_t;

  localparam logic [2:0] EXC_NONE     = 3'd0;
  localparam logic [2:0] EXC_TLB_MISS = 3'd1;
  localparam logic [2:0] EXC_TLB_INV  = 3'd2;
  localparam logic [2:0] EXC_TLB_MOD  = 3'd3;
  localparam logic [2:0] EXC_ADDR     = 3'd4;
  localparam logic [2:0] EXC_TIMEOUT  = 3'd5;

  state_t      state_q;
  logic        write_q;
  logic        signed_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;

  logic        req_ready_q;
  logic [31:0] vaddr_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [3:0]  bus_be_q;
  logic [31:0] bus_wdata_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic [2:0]  resp_exc_q;
  logic [31:0] resp_badvaddr_q;

  logic [2:0]  exc_d;
  logic        misalign_d;
  logic        tmo_hit;

  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    lane_enables = 4'b0001 << off;
      2'd1:    lane_enables = 4'b0011 << off;
      default: lane_enables = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'd0:    lane_replicate = {4{wd[7:0]}};
      2'd1:    lane_replicate = {2{wd[15:0]}};
      default: lane_replicate = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic sgn,
                                              input logic [1:0] off, input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> {off, 3'b000};
    case (size)
      2'd0:    load_extend = {{24{sgn & sh[7]}}, sh[7:0]};
      2'd1:    load_extend = {{16{sgn & sh[15]}}, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

  // Fault priority: alignment first, then the MMU flags; a dirty-page fault only matters for stores.
  assign misalign_d = ((size_q == 2'd1) && vaddr_q[0]) ||
                      (size_q[1] && (vaddr_q[1:0] != 2'b00));

  always_comb begin
    exc_d = EXC_NONE;
    if (misalign_d)                 exc_d = EXC_ADDR;
    else if (tlbMiss)               exc_d = EXC_TLB_MISS;
    else if (tlbInvalid)            exc_d = EXC_TLB_INV;
    else if (tlbModified && write_q) exc_d = EXC_TLB_MOD;
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] tmo_cnt_q;

  // Counter holds at zero outside BUS, so it is already clear on entry.
  always_ff @(posedge clk) begin
    if (res || (state_q != BUS)) tmo_cnt_q <= '0;
    else                         tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end

  assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (res) begin
      state_q         <= IDLE;
      req_ready_q     <= 1'b1;
      vaddr_q         <= '0;
      bus_req_q       <= 1'b0;
      bus_we_q        <= 1'b0;
      bus_addr_q      <= '0;
      bus_be_q        <= '0;
      bus_wdata_q     <= '0;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      resp_exc_q      <= EXC_NONE;
      resp_badvaddr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q     <= req_write;
            size_q      <= req_size;
            signed_q    <= req_signed;
            wdata_q     <= req_wdata;
            vaddr_q     <= req_addr;
            req_ready_q <= 1'b0;
            state_q     <= XLATE;
          end
        end
        XLATE: begin
          if (exc_d != EXC_NONE) begin
            resp_valid_q    <= 1'b1;
            resp_exc_q      <= exc_d;
            resp_badvaddr_q <= vaddr_q;
            resp_rdata_q    <= '0;
            state_q         <= RESP;
          end else begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= write_q;
            bus_addr_q  <= pAddr & 32'hFFFF_FFFC;
            bus_be_q    <= lane_enables(size_q, vaddr_q[1:0]);
            bus_wdata_q <= lane_replicate(size_q, wdata_q);
            state_q     <= BUS;
          end
        end
        BUS: begin
          if (bus_ack || tmo_hit) begin
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= '0;
            bus_wdata_q  <= '0;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
            if (bus_ack) begin
              resp_rdata_q    <= write_q ? 32'd0 : load_extend(size_q, signed_q, vaddr_q[1:0], bus_rdata);
              resp_exc_q      <= EXC_NONE;
              resp_badvaddr_q <= '0;
            end else begin
              resp_rdata_q    <= '0;
              resp_exc_q      <= EXC_TIMEOUT;
              resp_badvaddr_q <= vaddr_q;
            end
          end
        end
        RESP: begin
          resp_valid_q    <= 1'b0;
          resp_rdata_q    <= '0;
          resp_exc_q      <= EXC_NONE;
          resp_badvaddr_q <= '0;
          req_ready_q     <= 1'b1;
          state_q         <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign vAddr         = vaddr_q;
  assign bus_req       = bus_req_q;
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_be        = bus_be_q;
  assign bus_wdata     = bus_wdata_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_exc      = resp_exc_q;
  assign resp_badVAddr = resp_badvaddr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed test-plan cases plus randomized transactions
// against a behavioural model; the MMU is emulated as a fixed XOR translation of vAddr.
module tb_mem_access_unit;

  localparam int          TMO  = 4;
  localparam logic [31:0] XKEY = 32'h1F80_0000;

  logic        clk = 1'b0;
  logic        res;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, vAddr, pAddr;
  logic        tlbMiss, tlbInvalid, tlbModified;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        resp_valid;
  logic [31:0] resp_rdata, resp_badVAddr;
  logic [2:0]  resp_exc;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign pAddr = vAddr ^ XKEY;

  mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .res(res),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .vAddr(vAddr), .pAddr(pAddr),
    .tlbMiss(tlbMiss), .tlbInvalid(tlbInvalid), .tlbModified(tlbModified),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exc(resp_exc),
    .resp_badVAddr(resp_badVAddr)
  );

  // One complete request; delay < 0 means the bus never acknowledges.
  task automatic run_txn(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic miss, input logic inv, input logic mod,
                         input logic [31:0] rd, input int delay, input string tag);
    int off, waits, resp_cyc, limit, exp_cyc;
    logic [2:0]  exp_exc;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_rd, exp_bad, exp_baddr, lane;
    longint v;
    bit misal, fault, tmo, bus_seen;

    off   = int'(addr[1:0]);
    misal = (sz == 2'd1 && (off % 2) == 1) || (sz >= 2'd2 && off != 0);
    if (misal)            exp_exc = 3'd4;
    else if (miss)        exp_exc = 3'd1;
    else if (inv)         exp_exc = 3'd2;
    else if (mod && wr)   exp_exc = 3'd3;
    else                  exp_exc = 3'd0;
    fault = (exp_exc != 3'd0);
    tmo   = !fault && (delay < 0);
    if (tmo) exp_exc = 3'd5;

    exp_baddr = ((addr ^ XKEY) / 4) * 4;
    lane = rd >> (8 * off);
    if (sz == 2'd0) begin
      exp_be = 4'(1 << off);
      exp_wd = (wd % 256) * 32'h0101_0101;
      v = lane % 256;
      if (sg && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      exp_be = 4'(3 << off);
      exp_wd = (wd % 65536) * 32'h0001_0001;
      v = lane % 65536;
      if (sg && v >= 32768) v = v - 65536;
    end else begin
      exp_be = 4'hF;
      exp_wd = wd;
      v = lane;
    end
    exp_rd  = (wr || exp_exc != 3'd0) ? 32'd0 : 32'(v);
    exp_bad = (exp_exc != 3'd0) ? addr : 32'd0;
    exp_cyc = fault ? 2 : (tmo ? 2 + TMO : 3 + delay);
    limit   = exp_cyc + 8;

    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s.ready_idle: got %b expected 1", tag, req_ready);
    end
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    tlbMiss = miss; tlbInvalid = inv; tlbModified = mod;
    bus_rdata = ~rd;
    @(posedge clk);

    waits = delay; resp_cyc = -1; bus_seen = 0;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      @(negedge clk);
      req_valid = 1'b0; bus_ack = 1'b0; bus_rdata = ~rd;
      if (cyc == 1) begin
        n_cmp++;
        if (vAddr !== addr) begin
          n_fail++; $display("FAIL %s.vAddr: got %h expected %h", tag, vAddr, addr);
        end
      end
      if (resp_valid === 1'b1) begin
        resp_cyc = cyc;
        break;
      end
      n_cmp++;
      if (req_ready !== 1'b0) begin
        n_fail++; $display("FAIL %s.ready_busy: got %b expected 0 in cycle %0d", tag, req_ready, cyc);
      end
      if (bus_req === 1'b1) begin
        bus_seen = 1;
        n_cmp++;
        if (bus_addr !== exp_baddr) begin
          n_fail++; $display("FAIL %s.bus_addr: got %h expected %h", tag, bus_addr, exp_baddr);
        end
        n_cmp++;
        if (bus_be !== exp_be) begin
          n_fail++; $display("FAIL %s.bus_be: got %b expected %b", tag, bus_be, exp_be);
        end
        n_cmp++;
        if (bus_we !== wr) begin
          n_fail++; $display("FAIL %s.bus_we: got %b expected %b", tag, bus_we, wr);
        end
        if (wr) begin
          n_cmp++;
          if (bus_wdata !== exp_wd) begin
            n_fail++; $display("FAIL %s.bus_wdata: got %h expected %h", tag, bus_wdata, exp_wd);
          end
        end
        if (waits == 0) begin
          bus_ack = 1'b1; bus_rdata = rd;
        end else if (waits > 0) begin
          waits--;
        end
      end
    end

    n_cmp++;
    if (resp_cyc != exp_cyc) begin
      n_fail++; $display("FAIL %s.resp_cycle: got %0d expected %0d", tag, resp_cyc, exp_cyc);
    end
    n_cmp++;
    if (bus_seen != !fault) begin
      n_fail++; $display("FAIL %s.bus_activity: got %0d expected %0d", tag, bus_seen, !fault);
    end
    n_cmp++;
    if (resp_exc !== exp_exc) begin
      n_fail++; $display("FAIL %s.resp_exc: got %0d expected %0d", tag, resp_exc, exp_exc);
    end
    n_cmp++;
    if (resp_rdata !== exp_rd) begin
      n_fail++; $display("FAIL %s.resp_rdata: got %h expected %h", tag, resp_rdata, exp_rd);
    end
    n_cmp++;
    if (resp_badVAddr !== exp_bad) begin
      n_fail++; $display("FAIL %s.resp_badVAddr: got %h expected %h", tag, resp_badVAddr, exp_bad);
    end
    n_cmp++;
    if (bus_req !== 1'b0) begin
      n_fail++; $display("FAIL %s.bus_req_in_resp: got %b expected 0", tag, bus_req);
    end

    @(negedge clk);
    bus_ack = 1'b0;
    n_cmp++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || bus_req !== 1'b0) begin
      n_fail++; $display("FAIL %s.after_resp: got valid=%b ready=%b bus_req=%b expected 0/1/0",
                         tag, resp_valid, req_ready, bus_req);
    end
    tlbMiss = 1'b0; tlbInvalid = 1'b0; tlbModified = 1'b0;
  endtask

  task automatic test_reset;
    res = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset.req_ready: got %b expected 1", req_ready);
    end
    n_cmp++;
    if ({bus_req, bus_we, resp_valid} !== 3'b000 || bus_be !== 4'h0) begin
      n_fail++; $display("FAIL reset.ctrl: got req=%b we=%b valid=%b be=%h expected zeros",
                         bus_req, bus_we, resp_valid, bus_be);
    end
    n_cmp++;
    if ({vAddr, bus_addr, bus_wdata, resp_rdata, resp_badVAddr} !== 160'd0 || resp_exc !== 3'd0) begin
      n_fail++; $display("FAIL reset.data: got vAddr=%h bus_addr=%h exc=%0d expected zeros",
                         vAddr, bus_addr, resp_exc);
    end
    res = 1'b0;
  endtask

  task automatic test_loads;
    run_txn(1'b0, 2'd2, 1'b0, 32'h0040_0010, 32'h0, 0, 0, 0, 32'hDEAD_BEEF, 0, "word_load");
    run_txn(1'b0, 2'd0, 1'b1, 32'h0000_2002, 32'h0, 0, 0, 0, 32'h0080_0000, 0, "byte_load_s");
    run_txn(1'b0, 2'd0, 1'b0, 32'h0000_2002, 32'h0, 0, 0, 0, 32'h0080_0000, 0, "byte_load_u");
    run_txn(1'b0, 2'd1, 1'b1, 32'h0000_2006, 32'h0, 0, 0, 0, 32'h9ABC_1234, 2, "half_load_s");
    run_txn(1'b0, 2'd3, 1'b1, 32'h0000_2008, 32'h0, 0, 0, 0, 32'h8765_4321, 1, "size3_load");
  endtask

  task automatic test_stores;
    run_txn(1'b1, 2'd1, 1'b0, 32'h0000_1002, 32'h0000_1234, 0, 0, 0, 32'h5555_5555, 0, "half_store");
    run_txn(1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'hFFFF_FFA5, 0, 0, 0, 32'h0, 3, "byte_store");
    run_txn(1'b1, 2'd2, 1'b0, 32'h0000_1004, 32'hCAFE_F00D, 0, 0, 0, 32'h0, 0, "word_store");
  endtask

  task automatic test_faults;
    run_txn(1'b0, 2'd2, 1'b0, 32'h0000_1001, 32'h0, 1, 0, 0, 32'h0, 0, "misalign_beats_miss");
    run_txn(1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0, 1, 1, 1, 32'h0, 0, "tlb_miss");
    run_txn(1'b1, 2'd2, 1'b0, 32'h0000_1000, 32'h0, 0, 1, 1, 32'h0, 0, "tlb_invalid");
    run_txn(1'b1, 2'd0, 1'b0, 32'h0000_1001, 32'h77, 0, 0, 1, 32'h0, 0, "tlb_mod_store");
    run_txn(1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0, 0, 0, 1, 32'h1357_9BDF, 0, "tlb_mod_load");
    run_txn(1'b0, 2'd1, 1'b0, 32'h0000_1003, 32'h0, 0, 0, 0, 32'h0, 0, "half_misalign");
  endtask

  task automatic test_bus_wait;
`ifdef MEM_ACCESS_TIMEOUT_EN
    run_txn(1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'h0, 0, 0, 0, 32'h0, -1, "timeout");
`else
    int high_cnt;
    high_cnt = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h0000_3000;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (bus_req === 1'b1) high_cnt++;
    end
    n_cmp++;
    if (high_cnt != 120) begin
      n_fail++; $display("FAIL no_timeout.bus_req_held: got %0d cycles expected 120", high_cnt);
    end
    res = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res = 1'b0;
    n_cmp++;
    if (bus_req !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL no_timeout.recover: got req=%b ready=%b expected 0/1", bus_req, req_ready);
    end
`endif
  endtask

  task automatic test_reset_in_bus;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h0000_4000;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus_req !== 1'b1) begin
      n_fail++; $display("FAIL rst_bus.in_bus: got bus_req=%b expected 1", bus_req);
    end
    res = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res = 1'b0;
    n_cmp++;
    if (bus_req !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_bus.after: got req=%b valid=%b ready=%b expected 0/0/1",
                         bus_req, resp_valid, req_ready);
    end
    run_txn(1'b0, 2'd0, 1'b1, 32'h0000_4001, 32'h0, 0, 0, 0, 32'h0000_F100, 1, "rst_bus.follow");
  endtask

  task automatic test_random;
    logic        wr, sg, miss, inv, mod;
    logic [1:0]  sz;
    logic [31:0] addr, wd, rd;
    int          dly;
    for (int i = 0; i < 40; i++) begin
      wr   = 1'($urandom % 2);
      sg   = 1'($urandom % 2);
      sz   = 2'($urandom % 4);
      addr = $urandom;
      if ($urandom % 4 != 0) begin
        if (sz == 2'd1) addr[0] = 1'b0;
        else if (sz >= 2'd2) addr[1:0] = 2'b00;
      end
      wd   = $urandom;
      rd   = $urandom;
      miss = ($urandom % 8) == 0;
      inv  = ($urandom % 8) == 0;
      mod  = ($urandom % 4) == 0;
      dly  = int'($urandom_range(0, 3));
      run_txn(wr, sz, sg, addr, wd, miss, inv, mod, rd, dly, "random");
    end
  endtask

  initial begin
    res = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; tlbMiss = 1'b0; tlbInvalid = 1'b0; tlbModified = 1'b0;
    bus_ack = 1'b0; bus_rdata = '0;
    test_reset;
    test_loads;
    test_stores;
    test_faults;
    test_bus_wait;
    test_reset_in_bus;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store access sequencer sitting directly downstream of the MMU. Accepts one memory request at a time from the execute stage and drives the virtual address to the MMU. It then samples the translated physical address and TLB fault flags, and either reports an exception or runs a single bus transaction with a req/ack handshake. Read data is returned byte-lane aligned and extended.

## Interface
- TIMEOUT_CYCLES, 255: bus watchdog limit in cycles; only used when the watchdog is compiled in.
- clk  in  1  system clock; all state updates on the rising edge.
- res  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high together with req_valid.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- req_signed  in  1  sign-extend load data.
- req_addr  in  32  virtual address.
- req_wdata  in  32  store data, right-justified.
- vAddr  out  32  virtual address to the MMU (registered).
- pAddr  in  32  physical address from the MMU (combinational from vAddr).
- tlbMiss, tlbInvalid, tlbModified  in  1 each  MMU fault flags for vAddr.
- bus_req  out  1  bus transaction request.
- bus_we  out  1  write strobe.
- bus_addr  out  32  word-aligned physical address.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  transaction complete; bus_rdata is valid in the same cycle.
- bus_rdata  in  32  read data.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_exc  out  3  0 none, 1 TLB miss, 2 TLB invalid, 3 TLB modified, 4 address error, 5 bus timeout.
- resp_badVAddr  out  32  faulting virtual address; 0 when resp_exc = 0.

## Operation
- States: IDLE, XLATE, BUS, RESP.
- IDLE
  - req_ready = 1.
  - On handshake, capture addr, size, signed, write, and wdata; vAddr ← req_addr; go to XLATE.
- XLATE
  - Exactly one cycle; pAddr and the fault flags are sampled here.
  - Fault priority: address error (half with addr[0] set, or word with addr[1:0] ≠ 0), then tlbMiss, then tlbInvalid, then tlbModified.
  - tlbModified counts only when req_write = 1.
  - Any fault: go to RESP with the exception code and resp_badVAddr = vAddr; no bus activity.
  - No fault: latch the bus signals and go to BUS.
- BUS
  - bus_req = 1; bus_addr = {pAddr[31:2], 2'b00}.
  - bus_be: byte → 1 << addr[1:0]; half → 4'b0011 << addr[1:0]; word → 4'b1111.
  - bus_wdata: byte → data replicated ×4; half → data replicated ×2; word → as-is.
  - Address, data, and byte enables stay stable until bus_ack.
  - On bus_ack, capture rdata and go to RESP.
- RESP
  - resp_valid = 1 for one cycle, then back to IDLE.
  - Loads: resp_rdata = selected lane shifted down by addr[1:0]×8, sign- or zero-extended per req_signed.
- All outputs reset to 0 except req_ready, which is 1 in IDLE after reset. State resets to IDLE.

## Timing
- Handshake at edge 0, no fault, bus_ack in the first BUS cycle: resp_valid in cycle 3.
- Each extra wait cycle of bus_ack adds 1 cycle.
- Any fault: resp_valid in cycle 2.
- req_ready is low from XLATE through RESP, so there is no back-to-back overlap. Minimum request spacing is 3 cycles (fault) or 4 cycles (bus).
- bus_ack outside BUS is ignored.
- res during BUS: bus_req drops at the next edge. The transaction is abandoned; the slave must tolerate this.
- res during RESP: the pending response is discarded.

## Configuration
- MEM_ACCESS_TIMEOUT_EN defined
  - An 8-bit-or-wider counter runs in BUS.
  - When it reaches TIMEOUT_CYCLES without bus_ack, the unit drops bus_req and goes to RESP with resp_exc = 5, resp_badVAddr = vAddr, resp_rdata = 0.
  - The counter clears on entering BUS.
- Undefined: BUS waits indefinitely, and resp_exc = 5 is never produced.

## Test plan
- Word load from 0x00400010: pAddr = 0x1FC00010, no faults, bus_ack in the first BUS cycle, rdata 0xDEADBEEF → bus_addr 0x1FC00010, bus_be 4'hF, resp_valid in cycle 3, resp_rdata 0xDEADBEEF, resp_exc 0.
- Signed byte load at addr[1:0] = 2, rdata 0x00800000 → bus_be 4'b0100, resp_rdata 0xFFFFFF80. Repeat unsigned → 0x00000080.
- Half store at addr 0x1002, wdata 0x1234 → bus_we 1, bus_be 4'b1100, bus_wdata 0x12341234.
- Word load at 0x1001 with tlbMiss = 1 → resp_exc 4 (address error wins), resp_badVAddr 0x1001, bus_req never asserted. Aligned load with tlbMiss → exc 1. Store with only tlbModified → exc 3. Load with only tlbModified → exc 0 and a bus access.
- With MEM_ACCESS_TIMEOUT_EN and TIMEOUT_CYCLES = 4, bus_ack never asserted → resp_exc 5 after 4 BUS cycles, bus_req low afterwards. Without the macro, bus_req stays high for 100+ cycles.
- Assert res for 1 cycle during BUS → next cycle bus_req = 0, resp_valid = 0, req_ready = 1. A following request completes normally.
